// File: rtl/pitch_out_fifo.sv
// Output FIFO between the pitch-shift stage and the audio codec: primes to PRIME samples, then streams.
// Optional saturating drop/starve statistics are built when PITCH_OUT_FIFO_STATS_EN is defined.
module pitch_out_fifo #(
    parameter int D     = 16,
    parameter int PRIME = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          pitch_shift_out,
    input  logic                 pitch_shift_val,
    input  logic                 audio_out_ready,
    output logic [31:0]          audio_out_data,
    output logic                 audio_out_val,
    output logic [$clog2(D):0]   fifo_count
`ifdef PITCH_OUT_FIFO_STATS_EN
    ,
    output logic [15:0]          overflow_cnt,
    output logic [15:0]          underflow_cnt
`endif
);

    localparam int AW = $clog2(D);
    localparam int CW = AW + 1;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     hold_q, hold_d;
    logic [31:0]     mem [D];

    logic            full;
    logic            empty;
    logic            handshake;
    logic            pop;
    logic            push;
    logic            starve;
    logic [31:0]     head;

    assign full      = (count_q == CW'(D));
    assign empty     = (count_q == '0);
    assign head      = mem[rd_ptr_q];
    assign handshake = (state_q == RUN) && audio_out_ready;
    assign pop       = handshake && !empty;
    assign starve    = handshake && empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the sample.
    assign push      = pitch_shift_val && (!full || pop);

    // Outputs depend only on registered state, so ready never reaches val combinationally.
    assign audio_out_val  = (state_q == RUN);
    assign audio_out_data = ((state_q == RUN) && !empty) ? head : hold_q;
    assign fifo_count     = count_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        hold_d   = hold_q;

        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            hold_d   = head;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; combinational blocks above use blocking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FILL;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            hold_q   <= hold_d;
            unique case (state_q)
                FILL:    if (count_q >= CW'(PRIME)) state_q <= RUN;
                RUN:     if (starve)                state_q <= FILL;
                default:                            state_q <= FILL;
            endcase
        end
    end

    // NOTE: the sample RAM is deliberately not reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr_q] <= pitch_shift_out;
        end
    end

`ifdef PITCH_OUT_FIFO_STATS_EN
    logic        drop;
    logic [15:0] overflow_q, overflow_d;
    logic [15:0] underflow_q, underflow_d;

    assign drop = pitch_shift_val && full && !pop;

    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (drop && (overflow_q != 16'hFFFF)) begin
            overflow_d = overflow_q + 16'd1;
        end
        if (starve && (underflow_q != 16'hFFFF)) begin
            underflow_d = underflow_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= '0;
            underflow_q <= '0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow_cnt  = overflow_q;
    assign underflow_cnt = underflow_q;
`endif

endmodule

// File: tb/tb_pitch_out_fifo.sv
// Directed bench for pitch_out_fifo: a scoreboard queue holds accepted samples and is popped on each handshake.
// Statistics ports are connected and checked only when PITCH_OUT_FIFO_STATS_EN is defined.
module tb_pitch_out_fifo;

    localparam int D     = 16;
    localparam int PRIME = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pitch_shift_out;
    logic        pitch_shift_val;
    logic        audio_out_ready;
    logic [31:0] audio_out_data;
    logic        audio_out_val;
    logic [4:0]  fifo_count;
`ifdef PITCH_OUT_FIFO_STATS_EN
    logic [15:0] overflow_cnt;
    logic [15:0] underflow_cnt;
`endif

    always #10 clk = ~clk;

    pitch_out_fifo #(.D(D), .PRIME(PRIME)) dut (
        .clk             (clk),
        .rst             (rst),
        .pitch_shift_out (pitch_shift_out),
        .pitch_shift_val (pitch_shift_val),
        .audio_out_ready (audio_out_ready),
        .audio_out_data  (audio_out_data),
        .audio_out_val   (audio_out_val),
        .fifo_count      (fifo_count)
`ifdef PITCH_OUT_FIFO_STATS_EN
        ,
        .overflow_cnt    (overflow_cnt),
        .underflow_cnt   (underflow_cnt)
`endif
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] sb [$];
    logic [31:0] mdl_last;
    bit          mdl_run;
    int          mdl_ovf;
    int          mdl_unf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: compare outputs against the model, apply inputs, advance the model across the edge.
    task automatic cycle(input bit v, input logic [31:0] d, input bit rdy);
        int          cnt_pre;
        bit          hs;
        bit          st;
        bit          run_next;
        logic [31:0] exp;
        pitch_shift_val = v;
        pitch_shift_out = d;
        audio_out_ready = rdy;
        cnt_pre = sb.size();
        check("val", {31'b0, audio_out_val}, {31'b0, mdl_run});
        check("count", 32'(fifo_count), 32'(cnt_pre));
`ifdef PITCH_OUT_FIFO_STATS_EN
        check("ovf_cnt", 32'(overflow_cnt), 32'(mdl_ovf));
        check("unf_cnt", 32'(underflow_cnt), 32'(mdl_unf));
`endif
        hs = mdl_run && rdy;
        st = hs && (cnt_pre == 0);
        if (hs) begin
            exp = (cnt_pre > 0) ? sb.pop_front() : mdl_last;
            check("data", audio_out_data, exp);
            mdl_last = exp;
            if (st && mdl_unf < 65535) mdl_unf++;
        end
        if (v) begin
            if (sb.size() < D) sb.push_back(d);
            else if (mdl_ovf < 65535) mdl_ovf++;
        end
        run_next = mdl_run ? !st : (cnt_pre >= PRIME);
        @(posedge clk);
        #1;
        mdl_run = run_next;
        pitch_shift_val = 1'b0;
        audio_out_ready = 1'b0;
    endtask

    // Reset with a strobe and ready active, which must both be ignored.
    task automatic do_reset(input int n);
        rst = 1'b1;
        pitch_shift_val = 1'b1;
        pitch_shift_out = 32'hDEAD_BEEF;
        audio_out_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        pitch_shift_val = 1'b0;
        audio_out_ready = 1'b0;
        sb.delete();
        mdl_run  = 1'b0;
        mdl_last = '0;
        mdl_ovf  = 0;
        mdl_unf  = 0;
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_val", {31'b0, audio_out_val}, 32'd0);
        check("rst_data", audio_out_data, 32'd0);
`ifdef PITCH_OUT_FIFO_STATS_EN
        check("rst_ovf", 32'(overflow_cnt), 32'd0);
        check("rst_unf", 32'(underflow_cnt), 32'd0);
`endif
    endtask

    initial begin
        rst = 1'b1;
        pitch_shift_out = '0;
        pitch_shift_val = 1'b0;
        audio_out_ready = 1'b0;

        // Prime: 8 edges of reset span the first 150 ns.
        do_reset(8);
        for (int i = 1; i <= 4; i++) cycle(1'b1, 32'(i), 1'b0);
        check("prime_cnt4", 32'(fifo_count), 32'd4);
        check("prime_val0_at_cnt4", {31'b0, audio_out_val}, 32'd0);
        cycle(1'b0, '0, 1'b0);
        check("prime_val1", {31'b0, audio_out_val}, 32'd1);
        check("prime_data1", audio_out_data, 32'd1);

        // Drain order then starve.
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);
        check("drain_repeat4", audio_out_data, 32'd4);
        check("drain_val_before_starve", {31'b0, audio_out_val}, 32'd1);
        cycle(1'b0, '0, 1'b1);
        check("starve_to_fill", {31'b0, audio_out_val}, 32'd0);
`ifdef PITCH_OUT_FIFO_STATS_EN
        check("starve_unf1", 32'(underflow_cnt), 32'd1);
`endif

        // Overflow: 20 strobes into a 16-deep FIFO.
        do_reset(1);
        for (int i = 0; i < 20; i++) cycle(1'b1, 32'(i), 1'b0);
        check("ovf_count16", 32'(fifo_count), 32'd16);
`ifdef PITCH_OUT_FIFO_STATS_EN
        check("ovf_cnt4", 32'(overflow_cnt), 32'd4);
`endif
        for (int i = 0; i < 16; i++) begin
            check("ovf_drain_order", audio_out_data, 32'(i));
            cycle(1'b0, '0, 1'b1);
        end
        check("ovf_drained", 32'(fifo_count), 32'd0);

        // Full with simultaneous push and pop.
        do_reset(1);
        for (int i = 0; i < 16; i++) cycle(1'b1, 32'(100 + i), 1'b0);
        cycle(1'b0, '0, 1'b0);
        check("full_run", {31'b0, audio_out_val}, 32'd1);
        cycle(1'b1, 32'd99, 1'b1);
        check("full_pp_count16", 32'(fifo_count), 32'd16);
`ifdef PITCH_OUT_FIFO_STATS_EN
        check("full_pp_no_drop", 32'(overflow_cnt), 32'd0);
`endif
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check("full_pp_99_16th", audio_out_data, 32'd99);
            cycle(1'b0, '0, 1'b1);
        end

        // Wrap: 40 samples, one strobe and one ready every third cycle.
        do_reset(1);
        for (int i = 0; i < 120; i++) begin
            cycle((i % 3) == 0, 32'(1000 + i / 3), (i % 3) == 2);
        end
        while (sb.size() > 0) cycle(1'b0, '0, 1'b1);
        check("wrap_empty", 32'(fifo_count), 32'd0);
        check("wrap_last", audio_out_data, 32'd1039);
`ifdef PITCH_OUT_FIFO_STATS_EN
        check("wrap_no_drop", 32'(overflow_cnt), 32'd0);
`endif

        // Mid-run reset with 7 buffered samples.
        do_reset(1);
        for (int i = 0; i < 7; i++) cycle(1'b1, 32'(50 + i), 1'b0);
        check("mid_count7", 32'(fifo_count), 32'd7);
        check("mid_run", {31'b0, audio_out_val}, 32'd1);
        do_reset(1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'(200 + i), 1'b0);
        cycle(1'b0, '0, 1'b0);
        check("mid_val0_cnt3", {31'b0, audio_out_val}, 32'd0);
        cycle(1'b1, 32'd203, 1'b0);
        check("mid_val0_cnt4", {31'b0, audio_out_val}, 32'd0);
        cycle(1'b0, '0, 1'b0);
        check("mid_val1", {31'b0, audio_out_val}, 32'd1);
        check("mid_data200", audio_out_data, 32'd200);

        // Push and pop together at count=1: the new sample becomes the head.
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
        check("one_count1", 32'(fifo_count), 32'd1);
        cycle(1'b1, 32'd204, 1'b1);
        check("one_pp_count1", 32'(fifo_count), 32'd1);
        check("one_pp_head", audio_out_data, 32'd204);
        cycle(1'b0, '0, 1'b1);
        check("one_pp_hold", audio_out_data, 32'd204);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
